jpeg_dc_coeff_decode: RTL and testbench
=======================================

Name: jpeg_dc_coeff_decode

Overview:
- Bit-buffer and DC-coefficient stage wrapped around the combinational DC Huffman table lookup.
- Accepts an unstuffed entropy-coded byte stream and presents a 16-bit left-aligned window to the table.
- Consumes the returned code width, then extracts the category's extra bits and applies JPEG sign extension.
- Adds the difference to a per-component DC predictor and emits the absolute DC value on a valid/ready port.

Parameters:
- NUM_COMP, 3, number of DC predictors (component indices 0..NUM_COMP-1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- inport_valid_i  input  1  input byte valid.
- inport_data_i  input  8  entropy byte, MSB first, 0xFF00 stuffing already removed.
- inport_accept_o  output  1  byte accepted when valid && accept.
- start_i  input  1  single-cycle pulse; decode one DC coefficient; sampled only in IDLE.
- comp_i  input  2  component index, sampled with start_i.
- restart_i  input  1  RSTn marker / new scan: clears buffer, predictors and error.
- lookup_input_o  output  16  top 16 bits of the bit buffer, to the Huffman table.
- lookup_width_i  input  5  code length from the table (0 = no match).
- lookup_value_i  input  8  category from the table.
- outport_valid_o  output  1  DC result valid.
- outport_dc_o  output  16  signed absolute DC value.
- outport_comp_o  output  2  component of the result.
- outport_ready_i  input  1  downstream ready.
- busy_o  output  1  high in any state except IDLE.
- error_o  output  1  sticky decode error.

Behaviour:
- Bit buffer: 32-bit, left-aligned, with count 0..32.
  - inport_accept_o = (count <= 24) and state != ERROR.
  - An accepted byte is appended at bit position (31 - count).
  - Consume and append may occur in the same cycle. The shift is applied first, then the byte is placed at the post-shift count.
- lookup_input_o = buffer[31:16], combinational. Bits below count are zero.
- Reset and restart:
  - Reset (async) and restart_i (sync) both clear: state to IDLE, count = 0, all predictors = 0, outport_valid_o = 0, outport_dc_o = 0, outport_comp_o = 0, error_o = 0.
  - restart_i has priority over all other events in the same cycle, including an in-flight decode and a pending output. The pending output is dropped.
- FSM states:
  - IDLE: on start_i, latch comp_i and go to LOOKUP.
  - LOOKUP: wait until count >= 16.
    - If lookup_width_i == 0 or lookup_value_i > 11: set error_o and go to ERROR.
    - Otherwise shift out lookup_width_i bits, latch cat = lookup_value_i[3:0] and go to EXTRA.
  - EXTRA: wait until count >= cat (cat = 0 proceeds immediately with diff = 0).
    - Take e = buffer[31:32-cat] and shift out cat bits.
    - diff = e if e[cat-1] = 1; otherwise diff = e - (2^cat - 1).
    - pred[comp] = pred[comp] + diff, 16-bit two's complement.
    - Load outport_dc_o with the new predictor value and go to OUT.
  - OUT: outport_valid_o = 1. Data is held stable until outport_ready_i; on ready go to IDLE.
  - ERROR: holds until restart_i. No bytes are accepted and start_i is ignored.
- Latency: with count >= 16 at start_i, outport_valid_o rises 3 cycles after the start_i cycle (LOOKUP, EXTRA, OUT).
- Back-to-back: a start_i in the same cycle as the OUT->IDLE handshake is ignored. The next start_i is taken from IDLE.
- comp_i >= NUM_COMP: treated as a decode error; set error_o and go to ERROR from IDLE.

Optional Feature:
- Macro JPEG_DC_SATURATE_EN.
- With the macro defined: the predictor sum is clamped to [-2048, 2047] before storage and output.
- Without it: the 16-bit sum wraps modulo 2^16.

Test Plan:
- Reset, then feed 0x00,0x00, start comp 0 -> table gets 0x0000, width 2, cat 0; outport_dc_o = 0x0000 valid 3 cycles after start; count = 14.
- Feed 0x68,0x00,0x00 (code 011, extra 01), start comp 0 -> diff -2, dc = 0xFFFE. Start comp 0 again with "01101" bits queued -> dc = 0xFFFC (-4). Comp 1 remains 0.
- Cat 11: bits 111111110 then 11 ones -> dc = 2047 (0x07FF). Repeat -> 0x0FFE without the macro, 0x07FF with JPEG_DC_SATURATE_EN.
- Feed 0xFF,0xFF, start -> width 0, error_o = 1, inport_accept_o = 0. Then pulse restart_i -> error_o = 0, count = 0, predictors = 0, state IDLE.
- Hold outport_ready_i = 0 for 5 cycles -> outport_valid_o and outport_dc_o stable. A start_i during OUT is ignored. Ready for 1 cycle -> valid drops next cycle.
- Starve input: start with count = 8 -> remains in LOOKUP, no output. Deliver bytes one per 4 cycles -> result identical to the unstarved decode, no bits lost across simultaneous consume and append.

Source files
------------

// File: rtl/jpeg_dc_coeff_decode_if.sv
// Byte input, Huffman-table lookup and DC result bundle for jpeg_dc_coeff_decode.
interface jpeg_dc_coeff_decode_if;
  logic        inport_valid_i;
  logic [7:0]  inport_data_i;
  logic        inport_accept_o;
  logic [15:0] lookup_input_o;
  logic [4:0]  lookup_width_i;
  logic [7:0]  lookup_value_i;
  logic        outport_valid_o;
  logic [15:0] outport_dc_o;
  logic [1:0]  outport_comp_o;
  logic        outport_ready_i;

  modport master (
    output inport_valid_i, inport_data_i, lookup_width_i, lookup_value_i, outport_ready_i,
    input  inport_accept_o, lookup_input_o, outport_valid_o, outport_dc_o, outport_comp_o
  );
  modport slave (
    input  inport_valid_i, inport_data_i, lookup_width_i, lookup_value_i, outport_ready_i,
    output inport_accept_o, lookup_input_o, outport_valid_o, outport_dc_o, outport_comp_o
  );
endinterface

// File: rtl/jpeg_dc_coeff_decode.sv
// JPEG DC coefficient stage: bit buffer, Huffman width consume, extra-bit sign extension, DC prediction.
// Optional JPEG_DC_SATURATE_EN clamps the predictor to [-2048, 2047]; default wraps modulo 2^16.
module jpeg_dc_coeff_decode #(
  parameter int NUM_COMP = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            comp_i,
  input  logic                  restart_i,
  jpeg_dc_coeff_decode_if.slave bus,
  output logic                  busy_o,
  output logic                  error_o
);
  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_EXTRA, ST_OUT, ST_ERROR} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               buf_q, buf_d, buf_sh;
  logic [5:0]                cnt_q, cnt_d, cnt_sh, shamt;
  logic [1:0]                comp_q, comp_d;
  logic [3:0]                cat_q, cat_d;
  logic [NUM_COMP-1:0][15:0] pred_q, pred_d;
  logic [15:0]               dc_q, dc_d, extra, diff, sum;
  logic                      err_q, err_d, accept;

  assign accept              = (cnt_q <= 6'd24) && (state_q != ST_ERROR);
  assign bus.inport_accept_o = accept;
  assign bus.lookup_input_o  = buf_q[31:16];
  assign bus.outport_valid_o = (state_q == ST_OUT);
  assign bus.outport_dc_o    = dc_q;
  assign bus.outport_comp_o  = comp_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign error_o             = err_q;

  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    cat_d   = cat_q;
    pred_d  = pred_q;
    dc_d    = dc_q;
    err_d   = err_q;
    shamt   = '0;
    diff    = '0;
    sum     = '0;
    // cat 0 shifts by 32, which yields zero extra bits
    extra   = 16'(buf_q >> (6'd32 - {2'b00, cat_q}));
    case (state_q)
      ST_IDLE: if (start_i) begin
        if (int'(comp_i) >= NUM_COMP) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          comp_d  = comp_i;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: if (cnt_q >= 6'd16) begin
        // widths beyond the 16-bit window cannot come from a legal table
        if (bus.lookup_width_i == 5'd0 || bus.lookup_width_i > 5'd16 ||
            bus.lookup_value_i > 8'd11) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          shamt   = {1'b0, bus.lookup_width_i};
          cat_d   = bus.lookup_value_i[3:0];
          state_d = ST_EXTRA;
        end
      end
      ST_EXTRA: if (cnt_q >= {2'b00, cat_q}) begin
        shamt = {2'b00, cat_q};
        if (cat_q != 4'd0)
          diff = extra[cat_q - 4'd1] ? extra : extra - ((16'd1 << cat_q) - 16'd1);
        sum = pred_q[comp_q] + diff;
`ifdef JPEG_DC_SATURATE_EN
        if ($signed(sum) > 16'sd2047)       sum = 16'h07FF;
        else if ($signed(sum) < -16'sd2048) sum = 16'hF800;
`endif
        pred_d[comp_q] = sum;
        dc_d           = sum;
        state_d        = ST_OUT;
      end
      ST_OUT: if (bus.outport_ready_i) state_d = ST_IDLE;
      default: ;
    endcase
    // consume first, then append the new byte just below the surviving bits
    buf_sh = buf_q << shamt;
    cnt_sh = cnt_q - shamt;
    buf_d  = buf_sh;
    cnt_d  = cnt_sh;
    if (bus.inport_valid_i && accept) begin
      buf_d = buf_sh | ({bus.inport_data_i, 24'd0} >> cnt_sh);
      cnt_d = cnt_sh + 6'd8;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      comp_q  <= '0;
      cat_q   <= '0;
      pred_q  <= '0;
      dc_q    <= '0;
      err_q   <= 1'b0;
    end else if (restart_i) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      comp_q  <= '0;
      cat_q   <= '0;
      pred_q  <= '0;
      dc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      comp_q  <= comp_d;
      cat_q   <= cat_d;
      pred_q  <= pred_d;
      dc_q    <= dc_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_jpeg_dc_coeff_decode.sv
// Self-checking bench for jpeg_dc_coeff_decode: table vectors, corner sequences, random stream vs model.
module tb_jpeg_dc_coeff_decode;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       start_i = 1'b0;
  logic [1:0] comp_i = 2'd0;
  logic       restart_i = 1'b0;
  logic       busy_o, error_o;

  jpeg_dc_coeff_decode_if bus();

  jpeg_dc_coeff_decode #(.NUM_COMP(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .comp_i(comp_i),
    .restart_i(restart_i), .bus(bus.slave), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  // standard luminance DC table (category -> code, length)
  localparam int CODE_VAL [12] = '{0, 2, 3, 4, 5, 6, 14, 30, 62, 126, 254, 510};
  localparam int CODE_LEN [12] = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};

  always_comb begin
    bus.lookup_width_i = 5'd0;
    bus.lookup_value_i = 8'd0;
    for (int c = 0; c < 12; c++)
      if ((int'(bus.lookup_input_o) >> (16 - CODE_LEN[c])) == CODE_VAL[c]) begin
        bus.lookup_width_i = 5'(CODE_LEN[c]);
        bus.lookup_value_i = 8'(c);
      end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // byte feeder: drives the queue front, pops on a sampled handshake
  logic [7:0] feed_q[$];
  int         gap_mode = 0;  // -1: random 0..3 idle cycles between bytes
  initial begin
    int  gap_cnt;
    bit  take;
    gap_cnt = 0;
    bus.inport_valid_i = 1'b0;
    bus.inport_data_i  = 8'd0;
    forever begin
      @(negedge clk_i);
      take = bus.inport_valid_i && bus.inport_accept_o;
      @(posedge clk_i); #1;
      if (take) begin
        void'(feed_q.pop_front());
        gap_cnt = (gap_mode < 0) ? int'($urandom_range(3, 0)) : gap_mode;
      end
      if (gap_cnt > 0) begin
        bus.inport_valid_i = 1'b0;
        gap_cnt--;
      end else if (feed_q.size() > 0) begin
        bus.inport_valid_i = 1'b1;
        bus.inport_data_i  = feed_q[0];
      end else begin
        bus.inport_valid_i = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(); @(posedge clk_i); #1; endtask
  task automatic at_neg(); @(negedge clk_i); endtask

  bit bitq[$];
  task automatic put_bits(int v, int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(bit'((v >> i) & 1));
  endtask

  // encoder for one DC difference: category code followed by JPEG extra bits
  task automatic enc(int cat, int d);
    put_bits(CODE_VAL[cat], CODE_LEN[cat]);
    if (cat > 0) put_bits((d > 0) ? d : d + (1 << cat) - 1, cat);
  endtask

  task automatic flush(bit pad);
    logic [7:0] b;
    if (pad) begin
      put_bits(0, 16);
      while (bitq.size() % 8 != 0) bitq.push_back(1'b0);
    end
    while (bitq.size() >= 8) begin
      b = 8'd0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
      feed_q.push_back(b);
    end
  endtask

  function automatic int model_add(int p, int d);
    int s;
    logic [15:0] w;
    s = p + d;
`ifdef JPEG_DC_SATURATE_EN
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
`endif
    w = 16'(s);
    return int'($signed(w));
  endfunction

  task automatic restart();
    restart_i = 1'b1; tick(); restart_i = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int t = 0;
    while (busy_o !== 1'b0 && t < 400) begin tick(); t++; end
    if (t >= 400) chk({name, " idle timeout"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_valid(string name);
    int t = 0;
    while (bus.outport_valid_o !== 1'b1 && t < 400) begin tick(); t++; end
    chk({name, " valid"}, 32'(bus.outport_valid_o), 32'd1);
  endtask

  task automatic wait_drain(string name);
    int t = 0;
    while (feed_q.size() != 0 && t < 400) begin tick(); t++; end
    chk({name, " drain"}, 32'(feed_q.size()), 32'd0);
  endtask

  task automatic handshake();
    bus.outport_ready_i = 1'b1; tick(); bus.outport_ready_i = 1'b0;
  endtask

  task automatic do_decode(logic [1:0] comp, logic [15:0] exp, string name);
    wait_idle(name);
    start_i = 1'b1; comp_i = comp; tick(); start_i = 1'b0;
    wait_valid(name);
    chk({name, " dc"}, 32'(bus.outport_dc_o), 32'(exp));
    chk({name, " comp"}, 32'(bus.outport_comp_o), 32'(comp));
    handshake();
  endtask

  typedef struct {
    logic [1:0]  comp;
    int          cat;
    int          diff;
    logic [15:0] exp_dc;
  } vec_t;

  initial begin
    vec_t tbl [10];
    int   pm [3];
    int   rc [$], rexp [$];
    bus.outport_ready_i = 1'b0;

    tbl[0] = '{2'd0, 0,     0, 16'h0000};
    tbl[1] = '{2'd0, 2,    -2, 16'hFFFE};
    tbl[2] = '{2'd0, 2,    -2, 16'hFFFC};
    tbl[3] = '{2'd1, 0,     0, 16'h0000};
    tbl[4] = '{2'd2, 11, 2047, 16'h07FF};
`ifdef JPEG_DC_SATURATE_EN
    tbl[5] = '{2'd2, 11, 2047, 16'h07FF};
`else
    tbl[5] = '{2'd2, 11, 2047, 16'h0FFE};
`endif
    tbl[6] = '{2'd1, 1,     1, 16'h0001};
    tbl[7] = '{2'd1, 3,    -5, 16'hFFFC};
    tbl[8] = '{2'd0, 6,   -40, 16'hFFD4};
`ifdef JPEG_DC_SATURATE_EN
    tbl[9] = '{2'd2, 11, -2047, 16'h0000};
`else
    tbl[9] = '{2'd2, 11, -2047, 16'h07FF};
`endif

    #2 rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    at_neg();
    chk("rst valid", 32'(bus.outport_valid_o), 32'd0);
    chk("rst dc", 32'(bus.outport_dc_o), 32'd0);
    chk("rst comp", 32'(bus.outport_comp_o), 32'd0);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst error", 32'(error_o), 32'd0);
    chk("rst lookup", 32'(bus.lookup_input_o), 32'd0);
    chk("rst accept", 32'(bus.inport_accept_o), 32'd1);

    // two zero bytes: cat 0, exact 3-cycle latency, 14 bits left behind
    tick();
    feed_q.push_back(8'h00); feed_q.push_back(8'h00);
    repeat (4) tick();
    chk("zero window", 32'(bus.lookup_input_o), 32'd0);
    start_i = 1'b1; comp_i = 2'd0; tick(); start_i = 1'b0;
    at_neg(); chk("lat c1 valid", 32'(bus.outport_valid_o), 32'd0);
    at_neg(); chk("lat c2 valid", 32'(bus.outport_valid_o), 32'd0);
    at_neg(); chk("lat c3 valid", 32'(bus.outport_valid_o), 32'd1);
    chk("lat dc", 32'(bus.outport_dc_o), 32'd0);
    tick(); handshake();
    feed_q.push_back(8'hFF);
    repeat (4) tick();
    chk("count 14 window", 32'(bus.lookup_input_o), 32'h0003);
    restart();
    at_neg();
    chk("restart window", 32'(bus.lookup_input_o), 32'd0);

    // table-driven vectors on one continuous bit stream
    tick();
    foreach (tbl[i]) enc(tbl[i].cat, tbl[i].diff);
    flush(1'b1);
    foreach (tbl[i]) do_decode(tbl[i].comp, tbl[i].exp_dc, $sformatf("vec%0d", i));
    wait_drain("vec");
    restart();

    // decode error, sticky until restart, predictors cleared afterwards
    enc(1, 1);
    put_bits(32'hFFFFF, 20);
    flush(1'b0);
    do_decode(2'd0, 16'h0001, "pre-err");
    wait_idle("err");
    start_i = 1'b1; comp_i = 2'd0; tick(); start_i = 1'b0;
    repeat (3) tick();
    at_neg();
    chk("err flag", 32'(error_o), 32'd1);
    chk("err accept", 32'(bus.inport_accept_o), 32'd0);
    chk("err busy", 32'(busy_o), 32'd1);
    tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (3) tick();
    chk("err held", 32'(error_o), 32'd1);
    chk("err no out", 32'(bus.outport_valid_o), 32'd0);
    restart();
    at_neg();
    chk("clr error", 32'(error_o), 32'd0);
    chk("clr busy", 32'(busy_o), 32'd0);
    chk("clr window", 32'(bus.lookup_input_o), 32'd0);
    tick();
    enc(0, 0);
    flush(1'b1);
    do_decode(2'd0, 16'h0000, "pred cleared");
    wait_drain("pred");
    wait_idle("bad comp");
    start_i = 1'b1; comp_i = 2'd3; tick(); start_i = 1'b0;
    at_neg();
    chk("bad comp error", 32'(error_o), 32'd1);
    tick();
    restart();

    // output held under backpressure; start during OUT and at handshake ignored
    enc(4, 9);
    flush(1'b1);
    wait_idle("hold");
    start_i = 1'b1; comp_i = 2'd1; tick(); start_i = 1'b0;
    wait_valid("hold");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start_i = 1'b1;
      at_neg();
      chk($sformatf("hold%0d valid", i), 32'(bus.outport_valid_o), 32'd1);
      chk($sformatf("hold%0d dc", i), 32'(bus.outport_dc_o), 32'h0009);
      tick();
      start_i = 1'b0;
    end
    bus.outport_ready_i = 1'b1; start_i = 1'b1; comp_i = 2'd0;
    tick();
    bus.outport_ready_i = 1'b0; start_i = 1'b0;
    at_neg();
    chk("hs valid drop", 32'(bus.outport_valid_o), 32'd0);
    chk("hs start ignored", 32'(busy_o), 32'd0);
    tick();
    wait_drain("hold");
    restart();

    // starved input: only 8 bits buffered, then bytes trickle in every 4 cycles
    enc(2, -2); enc(5, 20); enc(7, -100); enc(3, 6);
    flush(1'b1);
    begin
      logic [7:0] rest [$];
      rest = feed_q;
      feed_q.delete();
      feed_q.push_back(rest.pop_front());
      repeat (4) tick();
      start_i = 1'b1; comp_i = 2'd0; tick(); start_i = 1'b0;
      repeat (6) tick();
      at_neg();
      chk("starve no out", 32'(bus.outport_valid_o), 32'd0);
      chk("starve busy", 32'(busy_o), 32'd1);
      tick();
      gap_mode = 4;
      foreach (rest[i]) feed_q.push_back(rest[i]);
    end
    wait_valid("starve0");
    chk("starve0 dc", 32'(bus.outport_dc_o), 32'hFFFE);
    handshake();
    do_decode(2'd0, 16'h0012, "starve1");
    do_decode(2'd1, 16'hFF9C, "starve2");
    do_decode(2'd0, 16'h0018, "starve3");
    wait_drain("starve");
    gap_mode = 0;
    restart();

    // random stream against the arithmetic model
    gap_mode = -1;
    pm = '{0, 0, 0};
    for (int k = 0; k < 60; k++) begin
      int c, cat, d, m;
      c   = int'($urandom_range(2, 0));
      cat = int'($urandom_range(11, 0));
      d   = 0;
      if (cat > 0) begin
        m = int'($urandom_range((1 << cat) - 1, 1 << (cat - 1)));
        d = ($urandom_range(1, 0) == 1) ? m : -m;
      end
      enc(cat, d);
      pm[c] = model_add(pm[c], d);
      rc.push_back(c);
      rexp.push_back(pm[c]);
    end
    flush(1'b1);
    foreach (rc[i]) do_decode(2'(rc[i]), 16'(rexp[i]), $sformatf("rnd%0d", i));
    wait_drain("rnd");
    gap_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
